// File: rtl/avmm_csr_master_if.sv
// Command/response and Avalon-MM signal bundle for avmm_csr_master.
// The master modport is the block's view; the slave modport is the
// environment's view (sequencer plus CSR slave).
interface avmm_csr_master_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              busy;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, avm_readdata, avm_waitrequest,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy,
               avm_address, avm_read, avm_write, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, avm_readdata, avm_waitrequest,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy,
               avm_address, avm_read, avm_write, avm_writedata
    );
endinterface

// File: rtl/avmm_csr_master.sv
// Single-beat Avalon-MM host for CSR slaves: one command in flight,
// waitrequest with bounded stall timeout, fixed read latency, one
// response pulse per command.
module avmm_csr_master #(
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    avmm_csr_master_if.master   bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RWAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [2:0]        lat_q, lat_d;

    // Everything on the bus is registered except the state decodes.
    assign bus.cmd_ready     = (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.avm_address   = addr_q;
    assign bus.avm_writedata = wdata_q;
    assign bus.avm_read      = rd_q;
    assign bus.avm_write     = wr_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rdata_q;
    assign bus.rsp_error     = err_q;

    // State and datapath registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            lat_q       <= lat_d;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        lat_d       = lat_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    wr_d    = bus.cmd_write;
                    rd_d    = ~bus.cmd_write;
                    tmo_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Acceptance wins over timeout on the same edge.
                if (!bus.avm_waitrequest) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (wr_q) begin
                        err_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else if (READ_LATENCY == 0) begin
                        rdata_d     = bus.avm_readdata;
                        err_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        lat_d   = 3'(READ_LATENCY);
                        state_d = RWAIT;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TW'(TIMEOUT - 1)) begin
                        rd_d        = 1'b0;
                        wr_d        = 1'b0;
                        err_d       = 1'b1;
                        rsp_valid_d = 1'b1;
                        if (rd_q) rdata_d = '0;
                        state_d     = RESP;
                    end
                end
            end
            RWAIT: begin
                // Counter reaching zero marks the readdata-valid edge.
                if (lat_q <= 3'd1) begin
                    lat_d       = '0;
                    rdata_d     = bus.avm_readdata;
                    err_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_avmm_csr_master.sv
// Directed bench for avmm_csr_master: u0 uses READ_LATENCY=1/TIMEOUT=8,
// u1 uses READ_LATENCY=0/TIMEOUT=8. Inputs driven and outputs sampled
// on the falling edge.
module tb_avmm_csr_master;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   nchk = 0;
    int   npass = 0;

    always #5 clk = ~clk;

    avmm_csr_master_if #(.ADDR_W(3), .DATA_W(32)) b0 ();
    avmm_csr_master_if #(.ADDR_W(3), .DATA_W(32)) b1 ();

    avmm_csr_master #(.ADDR_W(3), .DATA_W(32), .READ_LATENCY(1), .TIMEOUT(8))
        u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
    avmm_csr_master #(.ADDR_W(3), .DATA_W(32), .READ_LATENCY(0), .TIMEOUT(8))
        u1 (.clk(clk), .reset_n(reset_n), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cmd0(input logic wr, input logic [2:0] a, input logic [31:0] d);
        b0.cmd_valid = 1'b1;
        b0.cmd_write = wr;
        b0.cmd_addr  = a;
        b0.cmd_wdata = d;
    endtask

    initial begin
        b0.cmd_valid = 0; b0.cmd_write = 0; b0.cmd_addr = 0; b0.cmd_wdata = 0;
        b0.avm_readdata = 0; b0.avm_waitrequest = 0;
        b1.cmd_valid = 0; b1.cmd_write = 0; b1.cmd_addr = 0; b1.cmd_wdata = 0;
        b1.avm_readdata = 0; b1.avm_waitrequest = 0;

        // Reset state
        #12;
        chk("rst_read", 32'(b0.avm_read), 0);
        chk("rst_write", 32'(b0.avm_write), 0);
        chk("rst_rspv", 32'(b0.rsp_valid), 0);
        chk("rst_rdata", b0.rsp_rdata, 0);
        chk("rst_addr", 32'(b0.avm_address), 0);
        chk("rst_wdata", b0.avm_writedata, 0);
        chk("rst_busy", 32'(b0.busy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("rdy_after_rst", 32'(b0.cmd_ready), 1);

        // Write, no stall
        cmd0(1'b1, 3'd1, 32'hA5A5_0003);
        tick();
        b0.cmd_valid = 0;
        chk("wr_strobe", 32'(b0.avm_write), 1);
        chk("wr_addr", 32'(b0.avm_address), 1);
        chk("wr_data", b0.avm_writedata, 32'hA5A5_0003);
        chk("wr_noread", 32'(b0.avm_read), 0);
        chk("wr_busy", 32'(b0.busy), 1);
        chk("wr_rdy", 32'(b0.cmd_ready), 0);
        tick();
        chk("wr_strobe_off", 32'(b0.avm_write), 0);
        chk("wr_rspv", 32'(b0.rsp_valid), 1);
        chk("wr_err", 32'(b0.rsp_error), 0);
        chk("wr_rdata", b0.rsp_rdata, 0);
        tick();
        chk("wr_rspv_once", 32'(b0.rsp_valid), 0);
        chk("wr_rdy_back", 32'(b0.cmd_ready), 1);

        // Read, latency 1, no stall
        cmd0(1'b0, 3'd0, 32'h0);
        tick();
        b0.cmd_valid = 0;
        chk("rd_strobe", 32'(b0.avm_read), 1);
        chk("rd_addr", 32'(b0.avm_address), 0);
        tick();
        chk("rd_strobe_off", 32'(b0.avm_read), 0);
        chk("rd_rwait_norsp", 32'(b0.rsp_valid), 0);
        b0.avm_readdata = 32'h0000_0012;
        tick();
        b0.avm_readdata = 32'hDEAD_BEEF;
        chk("rd_rspv", 32'(b0.rsp_valid), 1);
        chk("rd_rdata", b0.rsp_rdata, 32'h0000_0012);
        chk("rd_err", 32'(b0.rsp_error), 0);
        tick();
        chk("rd_rspv_once", 32'(b0.rsp_valid), 0);
        chk("rd_rdata_hold", b0.rsp_rdata, 32'h0000_0012);

        // Read stalled 3 cycles
        cmd0(1'b0, 3'd5, 32'h0);
        b0.avm_waitrequest = 1;
        tick();
        b0.cmd_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("st_read_hi", 32'(b0.avm_read), 1);
            chk("st_addr", 32'(b0.avm_address), 5);
            tick();
        end
        chk("st_read_hi4", 32'(b0.avm_read), 1);
        b0.avm_waitrequest = 0;
        tick();
        chk("st_read_off", 32'(b0.avm_read), 0);
        chk("st_norsp", 32'(b0.rsp_valid), 0);
        b0.avm_readdata = 32'h0000_0077;
        tick();
        chk("st_rspv", 32'(b0.rsp_valid), 1);
        chk("st_rdata", b0.rsp_rdata, 32'h0000_0077);
        chk("st_no_restrobe", 32'(b0.avm_read), 0);
        tick();
        chk("st_rspv_once", 32'(b0.rsp_valid), 0);

        // Timeout: waitrequest stuck high, TIMEOUT=8
        cmd0(1'b0, 3'd2, 32'h0);
        b0.avm_waitrequest = 1;
        tick();
        b0.cmd_valid = 0;
        for (int i = 0; i < 8; i++) begin
            chk("to_read_hi", 32'(b0.avm_read), 1);
            if (i < 7) tick();
        end
        tick();
        chk("to_read_off", 32'(b0.avm_read), 0);
        chk("to_rspv", 32'(b0.rsp_valid), 1);
        chk("to_err", 32'(b0.rsp_error), 1);
        chk("to_rdata", b0.rsp_rdata, 0);
        b0.avm_waitrequest = 0;
        tick();
        chk("to_rdy", 32'(b0.cmd_ready), 1);
        chk("to_rspv_once", 32'(b0.rsp_valid), 0);

        // Back-to-back: cmd_valid held high through busy
        cmd0(1'b1, 3'd3, 32'h1111_2222);
        tick();
        cmd0(1'b0, 3'd4, 32'h0);
        chk("bb_wr", 32'(b0.avm_write), 1);
        tick();
        chk("bb_rsp1", 32'(b0.rsp_valid), 1);
        chk("bb_no_early_rd", 32'(b0.avm_read), 0);
        chk("bb_rdata_keep", b0.rsp_rdata, 0);
        tick();
        chk("bb_idle_rdy", 32'(b0.cmd_ready), 1);
        chk("bb_idle_norsp", 32'(b0.rsp_valid), 0);
        tick();
        b0.cmd_valid = 0;
        chk("bb_rd", 32'(b0.avm_read), 1);
        chk("bb_rd_addr", 32'(b0.avm_address), 4);
        tick();
        chk("bb_rwait_norsp", 32'(b0.rsp_valid), 0);
        b0.avm_readdata = 32'h0000_0099;
        tick();
        chk("bb_rsp2", 32'(b0.rsp_valid), 1);
        chk("bb_rdata", b0.rsp_rdata, 32'h0000_0099);
        tick();
        chk("bb_rsp2_once", 32'(b0.rsp_valid), 0);

        // READ_LATENCY=0: capture on the acceptance edge
        b1.cmd_valid = 1; b1.cmd_write = 0; b1.cmd_addr = 3'd6;
        tick();
        b1.cmd_valid = 0;
        chk("l0_rd", 32'(b1.avm_read), 1);
        b1.avm_readdata = 32'h0000_0055;
        tick();
        b1.avm_readdata = 32'h0;
        chk("l0_rspv", 32'(b1.rsp_valid), 1);
        chk("l0_rdata", b1.rsp_rdata, 32'h0000_0055);
        tick();
        chk("l0_rspv_once", 32'(b1.rsp_valid), 0);

        // Reset while in RWAIT
        cmd0(1'b0, 3'd7, 32'h3333_4444);
        tick();
        b0.cmd_valid = 0;
        tick();
        chk("rr_in_rwait", 32'(b0.busy), 1);
        reset_n = 1'b0;
        #1;
        chk("rr_read", 32'(b0.avm_read), 0);
        chk("rr_addr", 32'(b0.avm_address), 0);
        chk("rr_wdata", b0.avm_writedata, 0);
        chk("rr_rdata", b0.rsp_rdata, 0);
        chk("rr_busy", 32'(b0.busy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_no_rsp", 32'(b0.rsp_valid), 0);
        end
        cmd0(1'b0, 3'd1, 32'h0);
        tick();
        b0.cmd_valid = 0;
        chk("rr2_rd", 32'(b0.avm_read), 1);
        tick();
        b0.avm_readdata = 32'hCAFE_0001;
        tick();
        chk("rr2_rspv", 32'(b0.rsp_valid), 1);
        chk("rr2_rdata", b0.rsp_rdata, 32'hCAFE_0001);
        chk("rr2_err", 32'(b0.rsp_error), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/avmm_csr_master.md
Name: avmm_csr_master

Overview:
- Parametrised Avalon-MM host for CSR-style slave register blocks, such as the dual-configuration controller's status and control registers.
- Accepts single-beat read/write commands from the upgrade sequencer over a valid/ready handshake.
- Honours waitrequest and a fixed read latency, with a bounded timeout on waitrequest.
- Returns one response pulse per command, carrying read data and an error flag.

Parameters:
ADDR_W, 3, width of the slave word address
DATA_W, 32, width of the data bus
READ_LATENCY, 1, cycles from read acceptance (waitrequest low) to valid readdata; legal range 0..7
TIMEOUT, 255, maximum cycles a request may be stalled by waitrequest before abort; must be at least 1

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target word address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data of the last completed read
rsp_error  out  1  qualified by rsp_valid; 1 = timeout abort
busy  out  1  high in every state except IDLE
avm_address  out  ADDR_W  Avalon address
avm_read  out  1  Avalon read strobe
avm_write  out  1  Avalon write strobe
avm_writedata  out  DATA_W  Avalon write data
avm_readdata  in  DATA_W  Avalon read data
avm_waitrequest  in  1  slave stall

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: every output is 0, including rsp_rdata, avm_address and avm_writedata, except cmd_ready. cmd_ready is 1 one cycle after reset_n deasserts, when the state is IDLE.
- Reset assertion mid-transaction: drops avm_read and avm_write immediately, abandons the transaction and issues no response.
- FSM states: IDLE, REQ, RWAIT, RESP. All outputs are registered except cmd_ready and busy, which decode the state.
- IDLE:
  - cmd_ready=1.
  - At the edge where cmd_valid=1, the block latches cmd_addr into avm_address and cmd_wdata into avm_writedata.
  - It sets avm_write=cmd_write and avm_read=~cmd_write, clears the timeout counter and goes to REQ.
  - cmd_valid while cmd_ready=0 is ignored, not queued.
- REQ:
  - avm_address, avm_writedata and the strobe are held stable.
  - The timeout counter increments on every edge that sees avm_waitrequest=1.
  - Acceptance edge (avm_waitrequest=0): the strobe deasserts at that edge.
    - Write: go to RESP, rsp_error=0.
    - Read with READ_LATENCY=0: capture avm_readdata at the same edge into rsp_rdata and go to RESP.
    - Read with READ_LATENCY>0: load the latency counter with READ_LATENCY and go to RWAIT.
  - Timeout: when waitrequest is still 1 and the counter reaches TIMEOUT-1, the strobe deasserts at that edge.
    - rsp_error=1; rsp_rdata is cleared to 0 for reads and unchanged for writes.
    - Go to RESP.
  - Acceptance takes priority over timeout on the same edge.
- RWAIT:
  - The latency counter decrements each edge.
  - On the edge where it reaches 0, the edge READ_LATENCY cycles after acceptance, capture avm_readdata into rsp_rdata and go to RESP.
  - No new strobe is issued in this state.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- rsp_rdata holds its value until the next read completes or times out. Writes never change it.
- Minimum latencies:
  - Write with no waitrequest: cmd accepted at edge 0, avm_write high in cycle 1, rsp_valid in cycle 2, cmd_ready again in cycle 3.
  - Read: the same plus READ_LATENCY cycles.
- Throughput: at most one command in flight. Back-to-back commands are spaced at least 3 cycles apart.
- Counter widths: the timeout counter is sized by $clog2(TIMEOUT+1) and the latency counter by 3 bits; neither wraps in normal use.

Test Plan:
- Write, ADDR_W=3, addr=1, wdata=0xA5A5_0003, waitrequest=0 -> avm_write high exactly 1 cycle with avm_address=1 and avm_writedata=0xA5A5_0003; rsp_valid 2 cycles after acceptance; rsp_error=0; rsp_rdata unchanged.
- Read, addr=0, READ_LATENCY=1, slave returns 0x0000_0012 one cycle after acceptance -> rsp_rdata=0x0000_0012 with rsp_valid 3 cycles after cmd acceptance; rsp_error=0.
- Read with waitrequest held high 3 cycles -> avm_read high 4 cycles with address stable; response delayed by exactly 3 cycles versus the unstalled case; no extra strobe.
- TIMEOUT=8, waitrequest stuck high on a read -> avm_read drops after 8 stalled cycles; rsp_valid=1, rsp_error=1, rsp_rdata=0; cmd_ready returns the next cycle.
- Back-to-back: write then read issued as soon as cmd_ready rises; cmd_valid held high during busy -> second command accepted only in IDLE; exactly one rsp_valid per command; READ_LATENCY=0 variant captures on the acceptance edge.
- reset_n pulsed low while in RWAIT -> all outputs 0 asynchronously; no rsp_valid after release; next read completes normally.
